counter_updown_mod: RTL
=======================

Name: counter_updown_mod

Overview:
Parametrised successor to the fixed 8-bit free-running incrementer counter. Adds width and modulus generics, count enable, up/down direction, synchronous parallel load, and a wrap or saturate mode. Also adds a registered terminal-count pulse and a sticky overflow flag. It sits beside the ALU datapath as a general event/address counter and replaces hard-coded 8-bit counter instances.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MODULO, 256, count range 0..MODULO-1; must satisfy 2 <= MODULO <= 2**WIDTH
RESET_VAL, 0, count value after reset; must be < MODULO

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  asynchronous, active-low reset; all state is cleared while reset=0, and release is synchronous to clk externally
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 increments, 0 decrements
sat  input  1  mode: 0 wraps at boundaries, 1 saturates at boundaries
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load
clr_ovf  input  1  synchronous clear of the sticky overflow flag
count  output  WIDTH  registered count value
tc  output  1  registered terminal-count pulse
ovf  output  1  sticky boundary-hit flag

Behaviour:
- Reset (reset=0, asynchronous): count=RESET_VAL, tc=0, ovf=0. All outputs are held while reset is low. If reset is asserted mid-count, the count is abandoned with no tc or ovf side effect.
- MAX denotes MODULO-1. All arithmetic is on WIDTH bits, and count never leaves 0..MAX.
- Per-cycle priority is load > en > hold.
- load=1: count <= min(load_val, MAX); tc <= 0; ovf is unchanged. A load_val above MAX is clamped to MAX, not wrapped.
- load=0, en=1, up=1:
  - count<MAX: count+1.
  - count==MAX, sat=0: count <= 0, tc <= 1, ovf <= 1.
  - count==MAX, sat=1: count holds MAX, tc <= 0, ovf <= 1.
- load=0, en=1, up=0:
  - count>0: count-1.
  - count==0, sat=0: count <= MAX, tc <= 1, ovf <= 1.
  - count==0, sat=1: count holds 0, tc <= 0, ovf <= 1.
- en=0 and load=0: count holds, tc <= 0.
- tc is high for exactly one cycle: the first cycle in which the wrapped value is visible on count. Back-to-back wraps give a tc pulse each wrap. For example, MODULO=2 counting continuously gives tc on every second cycle.
- Latency: every change to count, tc and ovf appears one clk edge after the causing inputs are sampled.
- ovf is sticky until clr_ovf=1, which clears it on the next edge. If clr_ovf=1 and a boundary event occur in the same cycle, set wins (ovf=1).
- up and sat are sampled every cycle and may change at any time; there is no internal mode state.
- When MODULO=2**WIDTH, the wrap compare reduces to all-ones and all-zeros detection. The synthesised result must match the generic path.

Decomposition:
- Shared package counter_pkg holds:
  - the direction constants DIR_DOWN=0 and DIR_UP=1;
  - the mode constants MODE_WRAP=0 and MODE_SAT=1;
  - a function clamp_to_max(val, max) used by the load path.
- One combinational sub-module, counter_next_calc, takes (count, up, sat, MAX) and returns next_count, wrap_evt and bound_evt.
- The top level holds the three registers (count, tc, ovf) on the async active-low reset and the load/en priority mux.

Test Plan:
- Reset release with RESET_VAL=0, then en=1, up=1, sat=0 for 256 cycles (WIDTH=8, MODULO=256) -> count steps 0..255, then reads 0; tc=1 for one cycle with count=0; ovf=1.
- MODULO=10, WIDTH=4: load=1 with load_val=15 -> count=9. Then en=1, up=1, sat=1 for 3 cycles -> count stays 9, tc stays 0, ovf=1.
- MODULO=10: count=0, en=1, up=0, sat=0 -> count=9 next cycle, tc pulses once. Assert clr_ovf alone on the following cycle -> ovf=0.
- Simultaneous clr_ovf=1 with a wrap event (count=255, up=1, en=1) -> count=0, tc=1, ovf remains 1.
- load=1 and en=1 in the same cycle with count=5 and load_val=200 -> count=200 (load wins), tc=0.
- Drive reset=0 asynchronously mid-cycle while count=123 and en=1 -> count=RESET_VAL, tc=0 and ovf=0 immediately, with no clk edge needed. Counting resumes from RESET_VAL after release.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down event counter.
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Load values above the modulus are pinned to the top of the range, never wrapped.
  function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-step calculation: one count step in the requested direction,
// plus boundary (any edge hit) and wrap (edge crossed in wrap mode) events.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             bound_evt
);

  logic at_top;
  logic at_bottom;

  // With a full-range modulus max_val is all-ones, so these reduce to plain AND/NOR.
  assign at_top    = (count == max_val);
  assign at_bottom = (count == '0);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    next_count = count;
    wrap_evt   = 1'b0;
    bound_evt  = 1'b0;
    if (up == DIR_UP) begin
      if (at_top) begin
        bound_evt = 1'b1;
        if (sat == MODE_WRAP) begin
          next_count = '0;
          wrap_evt   = 1'b1;
        end
      end else begin
        next_count = count + WIDTH'(1);
      end
    end else begin
      if (at_bottom) begin
        bound_evt = 1'b1;
        if (sat == MODE_WRAP) begin
          next_count = max_val;
          wrap_evt   = 1'b1;
        end
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised modulo up/down counter with load, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow flag.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 8,
  parameter longint MODULO    = 256,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;
  logic             bound_evt;
  logic [WIDTH-1:0] load_clamped;

  counter_next_calc #(.WIDTH(WIDTH)) u_next (
    .count     (count),
    .up        (up),
    .sat       (sat),
    .max_val   (MAX),
    .next_count(next_count),
    .wrap_evt  (wrap_evt),
    .bound_evt (bound_evt)
  );

  assign load_clamped = WIDTH'(clamp_to_max(32'(load_val), 32'(MAX)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RST;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (load) begin
        count <= load_clamped;
        tc    <= 1'b0;
      end else if (en) begin
        count <= next_count;
        tc    <= wrap_evt;
      end else begin
        tc    <= 1'b0;
      end

      // A boundary hit in the same cycle as clr_ovf leaves the flag set.
      if (!load && en && bound_evt) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
